// File: rtl/conv_sequencer.sv
// Convolution layer sequencer: runs the external iterator once per output feature map.
// Latency: start accepted -> CLEAR next cycle; the done pulse comes one cycle after the last NEXT.
// Backpressure: out_ready=0 in RUN freezes the iterator and blocks writes with no state change.
// Optional feature macro: CONV_SEQUENCER_PERF_EN adds the cycle_count busy-cycle counter port.
module conv_sequencer #(
  parameter int MAP_W = 8,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [MAP_W-1:0] num_maps,
  input  logic             out_ready,
  input  logic             iter_save,
  input  logic             iter_finish,
  output logic             iter_en,
  output logic             iter_reset,
  output logic [MAP_W-1:0] map_idx,
  output logic             wr_en,
  output logic             busy,
  output logic             done
`ifdef CONV_SEQUENCER_PERF_EN
  ,
  output logic [CNT_W-1:0] cycle_count
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_RUN,
    S_NEXT,
    S_DONE
  } state_t;

  localparam logic [MAP_W-1:0] ONE = MAP_W'(1);

  state_t           state;
  state_t           state_nxt;
  logic [MAP_W-1:0] lat_maps;
  logic             accept;
  logic             kill;
  logic             last_map;

  // A start is only honoured in IDLE; abort only matters once a layer is under way.
  assign accept   = (state == S_IDLE) && start;
  assign kill     = abort && (state != S_IDLE);
  assign last_map = (map_idx == lat_maps - ONE);

  // Next-state and Moore outputs, with abort and then reset overriding everything.
  always_comb begin
    state_nxt  = state;
    iter_en    = 1'b0;
    iter_reset = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt = (num_maps == '0) ? S_DONE : S_CLEAR;
        end
      end
      S_CLEAR: begin
        busy       = 1'b1;
        iter_reset = 1'b1;
        state_nxt  = S_RUN;
      end
      S_RUN: begin
        busy    = 1'b1;
        iter_en = out_ready;
        if (iter_finish) begin
          state_nxt = S_NEXT;
        end
      end
      S_NEXT: begin
        busy      = 1'b1;
        state_nxt = last_map ? S_DONE : S_CLEAR;
      end
      S_DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
    // Abort drops the layer: clear the iterator, no write, no completion pulse.
    if (kill) begin
      state_nxt  = S_IDLE;
      iter_reset = 1'b1;
      iter_en    = 1'b0;
      done       = 1'b0;
    end
    // Reset holds the iterator cleared and reports the block as idle.
    if (reset) begin
      state_nxt  = S_IDLE;
      iter_reset = 1'b1;
      iter_en    = 1'b0;
      busy       = 1'b0;
      done       = 1'b0;
    end
  end

  // Writes only happen when the iterator is actually stepping.
  assign wr_en = iter_save && iter_en;

  // State, latched map count and map index; index holds across DONE/IDLE until the next start.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      lat_maps <= '0;
      map_idx  <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        lat_maps <= num_maps;
        map_idx  <= '0;
      end else if ((state == S_NEXT) && !kill && !last_map) begin
        map_idx <= map_idx + ONE;
      end
    end
  end

`ifdef CONV_SEQUENCER_PERF_EN
  // Busy-cycle counter: restarts on each accepted start, saturates rather than wrapping.
  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_count <= '0;
    end else if (accept) begin
      cycle_count <= '0;
    end else if (busy && (cycle_count != '1)) begin
      cycle_count <= cycle_count + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_conv_sequencer.sv
// Bench for conv_sequencer: each layer is expanded into an expected cycle schedule
// (per map: one CLEAR, the RUN cycles, one NEXT; then one DONE) and compared cycle by cycle.
// Inputs change at the falling edge; outputs are sampled 1ns later.
module tb_conv_sequencer;

  localparam int MAP_W = 8;
  localparam int CNT_W = 32;
  localparam int K_CLEAR = 1;
  localparam int K_RUN   = 2;
  localparam int K_NEXT  = 3;
  localparam int K_DONE  = 4;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic [MAP_W-1:0] num_maps = '0;
  logic             out_ready = 1'b0;
  logic             iter_save = 1'b0;
  logic             iter_finish = 1'b0;
  logic             iter_en;
  logic             iter_reset;
  logic [MAP_W-1:0] map_idx;
  logic             wr_en;
  logic             busy;
  logic             done;
`ifdef CONV_SEQUENCER_PERF_EN
  logic [CNT_W-1:0] cycle_count;
`endif

  int    vecs = 0;
  int    errs = 0;
  int    prev_idx = -1;
  longint perf_exp = 0;

  conv_sequencer #(.MAP_W(MAP_W), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .abort      (abort),
    .num_maps   (num_maps),
    .out_ready  (out_ready),
    .iter_save  (iter_save),
    .iter_finish(iter_finish),
    .iter_en    (iter_en),
    .iter_reset (iter_reset),
    .map_idx    (map_idx),
    .wr_en      (wr_en),
    .busy       (busy),
    .done       (done)
`ifdef CONV_SEQUENCER_PERF_EN
    ,
    .cycle_count(cycle_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outs(input string tag, input bit e_busy, input bit e_rst,
                            input bit e_en, input bit e_done, input int e_idx,
                            input bit chk_perf);
    chk({tag, ".busy"}, 32'(busy), 32'(e_busy));
    chk({tag, ".iter_reset"}, 32'(iter_reset), 32'(e_rst));
    chk({tag, ".iter_en"}, 32'(iter_en), 32'(e_en));
    chk({tag, ".wr_en"}, 32'(wr_en), 32'(e_en && iter_save));
    chk({tag, ".done"}, 32'(done), 32'(e_done));
    if (e_idx >= 0) chk({tag, ".map_idx"}, 32'(map_idx), 32'(e_idx));
`ifdef CONV_SEQUENCER_PERF_EN
    if (chk_perf) chk({tag, ".cycle_count"}, 32'(cycle_count), 32'(perf_exp));
`else
    if (chk_perf) begin end
`endif
  endtask

  function automatic void perf_tick();
    if (perf_exp < 64'hFFFF_FFFF) perf_exp++;
  endfunction

  // One layer: n maps, run length fixed_d (0 = random), pause = leading frozen RUN cycles,
  // rdy_all forces out_ready=1, abort_at/reset_at index into the schedule (-1 none, -2 random).
  task automatic run_layer(input string tag, input int n, input int fixed_d, input int pause,
                           input bit rdy_all, input int abort_at, input int reset_at);
    int kind[$];
    int sidx[$];
    bit fin[$];
    bit hold[$];
    int ab;
    int rs;
    for (int k = 0; k < n; k++) begin
      int d;
      d = (fixed_d > 0) ? fixed_d : $urandom_range(1, 5);
      kind.push_back(K_CLEAR); sidx.push_back(k); fin.push_back(0); hold.push_back(0);
      for (int p = 0; p < pause; p++) begin
        kind.push_back(K_RUN); sidx.push_back(k); fin.push_back(0); hold.push_back(1);
      end
      for (int j = 0; j < d; j++) begin
        kind.push_back(K_RUN); sidx.push_back(k); fin.push_back(j == d - 1); hold.push_back(0);
      end
      kind.push_back(K_NEXT); sidx.push_back(k); fin.push_back(0); hold.push_back(0);
    end
    kind.push_back(K_DONE); sidx.push_back(n > 0 ? n - 1 : -1); fin.push_back(0); hold.push_back(0);
    ab = (abort_at == -2) ? $urandom_range(0, kind.size() - 1) : abort_at;
    rs = (reset_at == -2) ? $urandom_range(0, kind.size() - 1) : reset_at;

    // Accepting cycle: still IDLE.
    @(negedge clk);
    start = 1'b1; num_maps = MAP_W'(n); abort = 1'b0; reset = 1'b0;
    iter_finish = 1'($urandom); out_ready = 1'($urandom); iter_save = 1'($urandom);
    #1;
    check_outs({tag, ".accept"}, 0, 0, 0, 0, prev_idx, 1);
    perf_exp = 0;

    for (int i = 0; i < kind.size(); i++) begin
      bit e_en;
      @(negedge clk);
      start = 1'($urandom); num_maps = MAP_W'($urandom);
      iter_save = 1'($urandom);
      out_ready = rdy_all ? 1'b1 : ($urandom_range(0, 2) != 0);
      iter_finish = (kind[i] == K_RUN) ? fin[i] : 1'($urandom);
      if (hold[i]) begin out_ready = 1'b0; iter_save = 1'b1; end
      if (fin[i]) out_ready = 1'b1;
      abort = (i == ab);
      reset = (i == rs);
      #1;
      if (reset) begin
        check_outs({tag, ".reset_mid"}, 0, 1, 0, 0, -1, 0);
        perf_exp = 0; prev_idx = 0;
        break;
      end else if (abort) begin
        check_outs({tag, ".abort"}, 1, 1, 0, 0, sidx[i], 1);
        perf_tick(); prev_idx = sidx[i];
        break;
      end else begin
        e_en = (kind[i] == K_RUN) && out_ready;
        check_outs({tag, ".seq"}, 1, kind[i] == K_CLEAR, e_en, kind[i] == K_DONE, sidx[i], 1);
        perf_tick(); prev_idx = sidx[i];
      end
    end

    // Back in IDLE: quiet outputs, index held, counter held.
    @(negedge clk);
    start = 1'b0; abort = 1'b0; reset = 1'b0;
    iter_finish = 1'($urandom); out_ready = 1'($urandom); iter_save = 1'($urandom);
    #1;
    check_outs({tag, ".idle"}, 0, 0, 0, 0, prev_idx, 1);
  endtask

  initial begin
    // Reset: outputs gated even with active-looking inputs.
    start = 1'b1; out_ready = 1'b1; iter_save = 1'b1; iter_finish = 1'b1; abort = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      check_outs("reset", 0, 1, 0, 0, (i > 0) ? 0 : -1, 0);
    end
    @(negedge clk);
    reset = 1'b0; start = 1'b0; abort = 1'b0;
    #1;
    perf_exp = 0; prev_idx = 0;
    check_outs("post_reset", 0, 0, 0, 0, 0, 1);

    run_layer("three_maps", 3, 5, 0, 1, -1, -1);
    run_layer("zero_maps", 0, 0, 0, 0, -1, -1);
    run_layer("pause", 2, 3, 4, 0, -1, -1);
    run_layer("abort_fin", 2, 3, 0, 1, 8, -1);
    run_layer("restart_ign", 2, 3, 0, 0, -1, -1);
    run_layer("perf_one", 1, 4, 0, 1, -1, -1);
`ifdef CONV_SEQUENCER_PERF_EN
    chk("perf_one.total", 32'(cycle_count), 32'd7);
`endif
    run_layer("reset_mid", 3, 2, 0, 0, -1, 6);
    for (int r = 0; r < 16; r++) begin
      int n;
      n = $urandom_range(0, 4);
      run_layer("rand", n, 0, $urandom_range(0, 2), 0,
                ($urandom_range(0, 3) == 0) ? -2 : -1,
                ($urandom_range(0, 5) == 0) ? -2 : -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
